// File: rtl/riscv_str_ops_ctrl.sv
// rtl/riscv_str_ops_ctrl.sv - sequencer between EX and the string-op unit: handshake, hold, capture, flush drain, timeout, op counter
module riscv_str_ops_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 32,
    parameter int STR_OP_WIDTH   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_i,
    input  logic [STR_OP_WIDTH-1:0] operator_i,
    input  logic [31:0]             operand_i,
    output logic                    req_ready_o,
    output logic [31:0]             result_o,
    output logic                    result_valid_o,
    input  logic                    ex_ready_i,
    input  logic                    flush_i,
    output logic                    timeout_o,
    output logic [CNT_WIDTH-1:0]    op_count_o,
    output logic                    unit_enable_o,
    output logic [STR_OP_WIDTH-1:0] unit_operator_o,
    output logic [31:0]             unit_operand_o,
    input  logic [31:0]             unit_result_i,
    input  logic                    unit_ready_i,
    output logic                    unit_ack_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [STR_OP_WIDTH-1:0] op_q;
    logic [31:0]             operand_q;
    logic [31:0]             result_q;
    logic [TW-1:0]           timer_q;
    logic [CNT_WIDTH-1:0]    count_q;

    logic accept;
    logic capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            operand_q <= '0;
            result_q  <= '0;
            timer_q   <= '0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q      <= operator_i;
                operand_q <= operand_i;
                timer_q   <= '0;
            end else if (state_q == BUSY) begin
                timer_q <= timer_q + TW'(1);
            end
            if (capture) begin
                result_q <= unit_result_i;
                if (!(&count_q)) begin
                    count_q <= count_q + CNT_WIDTH'(1);
                end
            end else if (timeout_o) begin
                result_q <= '0;
            end
        end
    end

    // Flush outranks ready and timeout in BUSY; a flushed or timed-out op must drain the unit.
    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        capture       = 1'b0;
        req_ready_o   = 1'b0;
        unit_enable_o = 1'b0;
        unit_ack_o    = 1'b0;
        timeout_o     = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_i && !flush_i) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                unit_enable_o = 1'b1;
                if (flush_i) begin
                    state_d = DRAIN;
                end else if (unit_ready_i) begin
                    capture    = 1'b1;
                    unit_ack_o = 1'b1;
                    state_d    = DONE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_o = 1'b1;
                    state_d   = DRAIN;
                end
            end
            DONE: begin
                if (ex_ready_i || flush_i) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                unit_ack_o = 1'b1;
                if (unit_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign result_o        = result_q;
    assign result_valid_o  = (state_q == DONE);
    assign op_count_o      = count_q;
    assign unit_operator_o = op_q;
    assign unit_operand_o  = operand_q;

endmodule
